// File: rtl/boot_loader.sv
// UART boot loader: assembles a length-prefixed little-endian word image, writes it to instruction ROM,
// then passes the ROM port through to the CPU. Optional trailer checksum check with BOOT_CHECKSUM_EN.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_data_i,
  input  logic        uart_valid_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_ce_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic        rom_op_o,
  output logic [31:0] rom_wr_data_o,
  output logic        cpu_stall_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  localparam logic ROM_OP_READ  = 1'b0;
  localparam logic ROM_OP_WRITE = 1'b1;

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic        wr_pend_q, wr_pend_d;
  logic [31:0] wr_buf_q, wr_buf_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        accept_c;
  logic        word_done_c;
  logic [31:0] full_word_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LEN;
      byte_cnt_q <= 2'd0;
      asm_q      <= 32'd0;
      len_q      <= 32'd0;
      word_cnt_q <= 32'd0;
      wr_pend_q  <= 1'b0;
      wr_buf_q   <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_buf_q   <= wr_buf_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Bytes are taken in every loading state, so capture overlaps the write cycle.
  assign accept_c    = uart_valid_i && (state_q != S_DONE) && (state_q != S_ERR);
  assign word_done_c = accept_c && (byte_cnt_q == 2'd3);
  assign full_word_c = {uart_data_i, asm_q[23:0]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    wr_pend_d  = 1'b0;
    wr_buf_d   = wr_buf_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (accept_c) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = uart_data_i;
        2'd1:    asm_d[15:8]  = uart_data_i;
        2'd2:    asm_d[23:16] = uart_data_i;
        default: asm_d[31:24] = uart_data_i;
      endcase
    end

    case (state_q)
      S_LEN: begin
        if (word_done_c) begin
          len_d      = full_word_c;
          word_cnt_d = 32'd0;
`ifdef BOOT_CHECKSUM_EN
          csum_d     = 32'd0;
          if (full_word_c == 32'd0)                  state_d = S_CHK;
`else
          if (full_word_c == 32'd0)                  state_d = S_DONE;
`endif
          else if (full_word_c > 32'(MAX_WORDS))     state_d = S_ERR;
          else                                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done_c) begin
          wr_pend_d = 1'b1;
          wr_buf_d  = full_word_c;
`ifdef BOOT_CHECKSUM_EN
          csum_d    = csum_q ^ full_word_c;
`endif
        end
        if (wr_pend_q) begin
          word_cnt_d = word_cnt_q + 32'd1;
          if (word_cnt_q == len_q - 32'd1) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (word_done_c) state_d = (full_word_c == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  // Port outputs decode straight from state so reset and the pass-through act immediately.
  always_comb begin
    rom_addr_o    = 32'd0;
    rom_ce_o      = 1'b0;
    rom_op_o      = ROM_OP_READ;
    rom_wr_data_o = 32'd0;
    cpu_stall_o   = 1'b1;
    boot_done_o   = 1'b0;
    boot_err_o    = 1'b0;
    case (state_q)
      S_DATA: begin
        if (wr_pend_q) begin
          rom_ce_o      = 1'b1;
          rom_op_o      = ROM_OP_WRITE;
          rom_addr_o    = BASE_ADDR + (word_cnt_q << 2);
          rom_wr_data_o = wr_buf_q;
        end
      end
      S_DONE: begin
        rom_addr_o  = cpu_addr_i;
        rom_ce_o    = cpu_ce_i;
        cpu_stall_o = 1'b0;
        boot_done_o = 1'b1;
      end
      S_ERR: boot_err_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader; a write log and sparse ROM image model catch every write.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  uart_data_i;
  logic        uart_valid_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_ce_i;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic        rom_op_o;
  logic [31:0] rom_wr_data_o;
  logic        cpu_stall_o;
  logic        boot_done_o;
  logic        boot_err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int unsigned wr_cyc_q[$];
  logic [31:0] rom_mem [logic [31:0]];
  int unsigned drv_cyc[$];

  boot_loader dut (
    .clk(clk), .rst(rst),
    .uart_data_i(uart_data_i), .uart_valid_i(uart_valid_i),
    .cpu_addr_i(cpu_addr_i), .cpu_ce_i(cpu_ce_i),
    .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o), .rom_op_o(rom_op_o),
    .rom_wr_data_o(rom_wr_data_o), .cpu_stall_o(cpu_stall_o),
    .boot_done_o(boot_done_o), .boot_err_o(boot_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && rom_ce_o && rom_op_o) begin
      wr_addr_q.push_back(rom_addr_o);
      wr_data_q.push_back(rom_wr_data_o);
      wr_cyc_q.push_back(cyc);
      rom_mem[rom_addr_o] = rom_wr_data_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data_i  = b;
    uart_valid_i = 1'b1;
    drv_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uart_valid_i = 1'b0;
    end
  endtask

  // Gapped send of one little-endian word.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      idle(1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    uart_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    drv_cyc.delete();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    uart_data_i = 8'h00;
    uart_valid_i = 1'b0;
    cpu_addr_i = 32'h0;
    cpu_ce_i = 1'b0;

    // Reset values
    #12;
    check("rst_ce", 32'(rom_ce_o), 32'd0);
    check("rst_op", 32'(rom_op_o), 32'd0);
    check("rst_addr", rom_addr_o, 32'd0);
    check("rst_wdata", rom_wr_data_o, 32'd0);
    check("rst_stall", 32'(cpu_stall_o), 32'd1);
    check("rst_done", 32'(boot_done_o), 32'd0);
    check("rst_err", 32'(boot_err_o), 32'd0);
    do_reset();

    // Two-word image, gapped bytes
    send_word(32'h0000_0002);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'hCC99_E897);
`endif
    idle(3);
    check("img2_nwr", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("img2_a0", wr_addr_q[0], 32'h0);
      check("img2_d0", wr_data_q[0], 32'h1234_5678);
      check("img2_a1", wr_addr_q[1], 32'h4);
      check("img2_d1", wr_data_q[1], 32'hDEAD_BEEF);
    end
    check("img2_done", 32'(boot_done_o), 32'd1);
    check("img2_stall", 32'(cpu_stall_o), 32'd0);
    w = rom_mem.exists(32'h0) ? rom_mem[32'h0] : 32'hxxxx_xxxx;
    check("img2_rd0", w, 32'h1234_5678);

    // Four words on back-to-back strobes
    do_reset();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h04 : 8'h00);
    drv_cyc.delete();
    for (int i = 0; i < 16; i++) send_byte(8'(i));
`ifdef BOOT_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(8'h00);
`endif
    idle(3);
    check("b2b_nwr", wr_addr_q.size(), 32'd4);
    if (wr_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        check($sformatf("b2b_a%0d", i), wr_addr_q[i], 32'(4*i));
        check($sformatf("b2b_d%0d", i), wr_data_q[i], w);
        check($sformatf("b2b_lat%0d", i), wr_cyc_q[i], drv_cyc[4*i+3] + 1);
      end
    end
    check("b2b_done", 32'(boot_done_o), 32'd1);

`ifndef BOOT_CHECKSUM_EN
    // Zero-length image goes straight to pass-through
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    check("len0_pre", 32'(boot_done_o), 32'd0);
    send_byte(8'h00);
    idle(1);
    check("len0_done", 32'(boot_done_o), 32'd1);
    cpu_addr_i = 32'h10;
    cpu_ce_i = 1'b1;
    #1;
    check("len0_addr", rom_addr_o, 32'h10);
    check("len0_ce", 32'(rom_ce_o), 32'd1);
    check("len0_op", 32'(rom_op_o), 32'd0);
    cpu_ce_i = 1'b0;
    #1;
    check("len0_ce_off", 32'(rom_ce_o), 32'd0);
    check("len0_nwr", wr_addr_q.size(), 32'd0);
    cpu_addr_i = 32'h0;
`endif

    // Length above MAX_WORDS
    do_reset();
    send_word(32'h0010_0001);
    check("big_err", 32'(boot_err_o), 32'd1);
    check("big_stall", 32'(cpu_stall_o), 32'd1);
    send_word(32'h0000_0001);
    send_word(32'h5555_5555);
    idle(2);
    check("big_err2", 32'(boot_err_o), 32'd1);
    check("big_done", 32'(boot_done_o), 32'd0);
    check("big_nwr", wr_addr_q.size(), 32'd0);

    // Boundary: exactly MAX_WORDS is accepted
    do_reset();
    send_word(32'h0010_0000);
    check("max_err", 32'(boot_err_o), 32'd0);
    check("max_stall", 32'(cpu_stall_o), 32'd1);

    // Reset mid-load, then a fresh one-word image
    do_reset();
    send_word(32'h0000_0002);
    send_byte(8'h11); idle(1);
    send_byte(8'h22); idle(1);
    do_reset();
    send_word(32'h0000_0001);
    send_word(32'hDDCC_BBAA);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'hDDCC_BBAA);
`endif
    idle(2);
    check("rl_nwr", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("rl_a0", wr_addr_q[0], 32'h0);
      check("rl_d0", wr_data_q[0], 32'hDDCC_BBAA);
    end
    check("rl_done", 32'(boot_done_o), 32'd1);

`ifdef BOOT_CHECKSUM_EN
    // Checksum match and mismatch
    do_reset();
    send_word(32'd2); send_word(32'd1); send_word(32'd2); send_word(32'd3);
    idle(2);
    check("ck_ok_done", 32'(boot_done_o), 32'd1);
    check("ck_ok_err", 32'(boot_err_o), 32'd0);
    do_reset();
    send_word(32'd2); send_word(32'd1); send_word(32'd2);
    idle(2);
    check("ck_bad_nwr", wr_addr_q.size(), 32'd2);
    check("ck_bad_pre", 32'(boot_done_o), 32'd0);
    send_word(32'd4);
    idle(2);
    check("ck_bad_err", 32'(boot_err_o), 32'd1);
    check("ck_bad_done", 32'(boot_done_o), 32'd0);
    do_reset();
    send_word(32'd0);
    idle(1);
    check("ck_len0_pre", 32'(boot_done_o), 32'd0);
    send_word(32'd0);
    idle(1);
    check("ck_len0_done", 32'(boot_done_o), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits directly upstream of the instruction-ROM wrapper.
- Receives a program image as a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word into instruction ROM through the wrapper's write port (addr/ce/op/wr_data), then hands the same port to the CPU fetch path as a pass-through.
- Keeps the CPU stalled until the image is fully loaded.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first image word; must be word-aligned.
- MAX_WORDS, 1048576, largest accepted image length in words.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- uart_data_i  in  8  received byte
- uart_valid_i  in  1  one-cycle strobe; uart_data_i is valid in that cycle
- cpu_addr_i  in  32  CPU fetch address (`InstAddrBus)
- cpu_ce_i  in  1  CPU fetch enable
- rom_addr_o  out  32  to wrapper addr_i
- rom_ce_o  out  1  to wrapper ce_i
- rom_op_o  out  1  to wrapper op_i (`ROM_OP_READ / `ROM_OP_WRITE)
- rom_wr_data_o  out  32  to wrapper wr_data_i (`InstBus)
- cpu_stall_o  out  1  holds the CPU while loading
- boot_done_o  out  1  image loaded; pass-through active
- boot_err_o  out  1  load aborted

Behaviour:
- Reset (async, rst=1), all outputs forced immediately:
  - rom_ce_o=0, rom_op_o=`ROM_OP_READ, rom_addr_o=0, rom_wr_data_o=0
  - cpu_stall_o=1, boot_done_o=0, boot_err_o=0
  - state=LEN, byte_cnt=0, word_cnt=0
- Byte assembly:
  - Byte k of a word (k=0..3) lands in bits [8k+7:8k].
  - byte_cnt is 2 bits and wraps 3->0 on each completed word.
  - A byte is accepted in any cycle of LEN or DATA, including a cycle in which a write is being issued.
- LEN state:
  - The first 4 bytes form len (word count).
  - len==0 -> DONE.
  - len>MAX_WORDS -> ERR.
  - Otherwise -> DATA with word_cnt=0.
- DATA state:
  - On the cycle the 4th byte of a word is captured, the word is latched into wr_buf.
  - The next cycle is exactly one write cycle: rom_ce_o=1, rom_op_o=`ROM_OP_WRITE, rom_addr_o=BASE_ADDR+4*word_cnt, rom_wr_data_o=wr_buf.
  - word_cnt increments at the end of the write cycle.
  - In non-write cycles: rom_ce_o=0, rom_op_o=`ROM_OP_READ.
  - After the write of word len-1 -> DONE, or -> CHK when the optional feature is compiled in.
- DONE state:
  - Combinational pass-through: rom_addr_o=cpu_addr_i, rom_ce_o=cpu_ce_i, rom_op_o=`ROM_OP_READ, rom_wr_data_o=0.
  - cpu_stall_o=0, boot_done_o=1.
  - uart_valid_i is ignored. DONE is left only by reset.
- ERR state:
  - rom_ce_o=0, cpu_stall_o=1, boot_err_o=1.
  - uart_valid_i is ignored. ERR is left only by reset.
- Latency: the write is issued 1 cycle after the strobe that delivered the 4th byte. Back-to-back strobes every cycle are supported without loss.
- Reset mid-load: partial word and counters are discarded; the already-written ROM contents are untouched; the next load starts with a fresh LEN.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no detection. BASE_ADDR+4*MAX_WORDS must fit the SRAM; the system integrator is responsible for this.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN
- Defined:
  - A 32-bit running XOR of all data words is maintained, cleared when leaving LEN.
  - After the last data word, state CHK collects 4 more bytes as a checksum word. No ROM write is issued for it.
  - Match -> DONE. Mismatch -> ERR.
  - len==0 still goes through CHK, and the expected checksum is 0.
- Undefined: no CHK state and no trailer bytes; boot_err_o is raised only by the length check.

Test Plan:
- Reset then bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> two write cycles: addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF. Afterwards boot_done_o=1 and cpu_stall_o=0. Read back via the wrapper at 0x0 gives 0x12345678.
- Bytes strobed on consecutive cycles for len=4 -> exactly 4 writes, each one cycle after its 4th byte; no byte lost; the write cycle overlaps capture of the next word's byte 0.
- len=0 (00 00 00 00, checksum macro undefined) -> no write; DONE the cycle after the 4th byte; cpu_addr_i=0x10 with cpu_ce_i=1 gives rom_addr_o=0x10, rom_op_o=READ.
- len=MAX_WORDS+1 -> ERR: boot_err_o=1, cpu_stall_o=1, no ROM write; later bytes ignored.
- Assert rst after 6 bytes of a len=2 image, then send a fresh len=1 image 01 00 00 00, AA BB CC DD -> single write at addr 0x0 with data 0xDDCCBBAA.
- BOOT_CHECKSUM_EN with words 0x1, 0x2 and trailer 03 00 00 00 -> DONE. Same image with trailer 04 00 00 00 -> ERR after both writes; boot_done_o stays 0.
